// File: rtl/alu_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq
//  Purpose  : Handshaked N-bit ALU with registered flags and shift-add MUL.
//  Revision : 1.0
// ============================================================================
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               carry_q;
  logic               zero_q;
  logic               overflow_q;
  logic               out_valid_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] prod_d;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel)
      3'b000: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        // The extra top bit of the difference is the unsigned borrow.
        sum     = {1'b0, a} - {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: alu_res = a | b;
      3'b011: alu_res = a & b;
      3'b100: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      3'b101: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      3'b110: begin
        sum     = {1'b0, a} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~a[WIDTH-1] & alu_res[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Upper half accumulates the multiplicand; lower half holds the shrinking multiplier.
  always_comb begin
    add_hi = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {add_hi, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (sel == 3'b111) begin
              mcand_q <= a;
              prod_q  <= {{WIDTH{1'b0}}, b};
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              result_q    <= alu_res;
              result_hi_q <= '0;
              carry_q     <= alu_c;
              zero_q      <= (alu_res == '0);
              overflow_q  <= alu_v;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q    <= prod_d[WIDTH-1:0];
            result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
            carry_q     <= |prod_d[2*WIDTH-1:WIDTH];
            zero_q      <= (prod_d == '0);
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_nbit_seq
//  Purpose  : Self-checking bench for alu_nbit_seq against an arithmetic model.
//  Revision : 1.0
// ============================================================================
module tb_alu_nbit_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         overflow;

  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference computed from integer arithmetic and signed ranges.
  function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint m, ux, uy, sx, sy, f, smax, smin;
    m    = longint'(1) << W;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = (ux >= m/2) ? ux - m : ux;
    sy   = (uy >= m/2) ? uy - m : uy;
    smax = m/2 - 1;
    smin = -(m/2);
    e    = '0;
    case (s)
      3'd0: begin
        f = ux + uy;  e.r = W'(f % m);  e.c = (f >= m);
        e.o = (sx + sy > smax) || (sx + sy < smin);
      end
      3'd1: begin
        e.r = W'((ux - uy + m) % m);  e.c = (ux < uy);
        e.o = (sx - sy > smax) || (sx - sy < smin);
      end
      3'd2: e.r = x | y;
      3'd3: e.r = x & y;
      3'd4: begin e.r = W'((ux * 2) % m);  e.c = (ux >= m/2); end
      3'd5: begin e.r = W'(ux / 2);        e.c = ((ux % 2) == 1); end
      3'd6: begin
        f = ux + 1;  e.r = W'(f % m);  e.c = (f >= m);  e.o = (sx + 1 > smax);
      end
      default: begin
        f = ux * uy;  e.r = W'(f % m);  e.hi = W'(f / m);
        e.c = (f >= m);  e.z = (f == 0);
      end
    endcase
    if (s != 3'd7) e.z = (e.r == '0);
    return e;
  endfunction

  // Transaction-level model: idle / waiting N cycles / holding a result.
  logic m_idle = 1'b1;
  logic m_valid = 1'b0;
  int   m_wait = 0;
  exp_t m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_exp  <= model(sel, a, b);
        m_idle <= 1'b0;
        if (sel == 3'd7) m_wait <= W;
        else             m_valid <= 1'b1;
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
      n_xfer  <= n_xfer + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", longint'(in_ready), longint'(m_idle));
      chk("out_valid", longint'(out_valid), longint'(m_valid));
      if (m_valid) begin
        chk("result", longint'(result), longint'(m_exp.r));
        chk("result_hi", longint'(result_hi), longint'(m_exp.hi));
        chk("carry", longint'(carry), longint'(m_exp.c));
        chk("zero", longint'(zero), longint'(m_exp.z));
        chk("overflow", longint'(overflow), longint'(m_exp.o));
      end
    end
  end

  task automatic issue(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    bit took;
    @(negedge clk); #1;
    in_valid = 1'b1;  sel = s;  a = x;  b = y;
    took = 1'b0;
    for (int i = 0; i < 40 && !took; i++) begin
      took = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r, input logic [W-1:0] hi,
                            input logic c, input logic z, input logic o);
    chk({name, "_result"}, longint'(result), longint'(r));
    chk({name, "_hi"}, longint'(result_hi), longint'(hi));
    chk({name, "_carry"}, longint'(carry), longint'(c));
    chk({name, "_zero"}, longint'(zero), longint'(z));
    chk({name, "_ovf"}, longint'(overflow), longint'(o));
  endtask

  task automatic release_out();
    @(negedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("xfer_out_valid", longint'(out_valid), 0);
    chk("xfer_in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    expect_out("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;

    issue(3'd0, 8'hFF, 8'h01);  wait_valid(0);
    expect_out("add", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    release_out();
    issue(3'd1, 8'h80, 8'h01);  wait_valid(0);
    expect_out("sub1", 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
    release_out();
    issue(3'd1, 8'h01, 8'h02);  wait_valid(0);
    expect_out("sub2", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    release_out();
    issue(3'd7, 8'hFF, 8'hFF);  wait_valid(W);
    expect_out("mul1", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0);
    release_out();
    issue(3'd7, 8'h00, 8'h5A);  wait_valid(W);
    expect_out("mul0", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    release_out();
    issue(3'd4, 8'h81, 8'h00);  wait_valid(0);
    expect_out("shl", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    release_out();
    issue(3'd5, 8'h81, 8'h00);  wait_valid(0);
    expect_out("shr", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    release_out();
    issue(3'd6, 8'h7F, 8'h00);  wait_valid(0);
    expect_out("inc", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
    release_out();

    // Backpressure with competing requests that must be ignored.
    issue(3'd0, 8'h12, 8'h34);  wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      in_valid = 1'b1;  sel = 3'd6;  a = 8'h00;
      @(posedge clk); #1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
      expect_out("bp", 8'h46, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    release_out();

    // Reset in the middle of a multiply.
    issue(3'd7, 8'h0F, 8'h0F);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", longint'(in_ready), 1);
    chk("arst_out_valid", longint'(out_valid), 0);
    expect_out("arst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", longint'(out_valid), 0);
    end
    issue(3'd3, 8'hF0, 8'h3C);  wait_valid(0);
    expect_out("and", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    release_out();

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      sel       = 3'($urandom);
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("random_activity", longint'(n_xfer > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Parametrised, handshaked N-bit ALU, successor to the 1-bit combinational ALU. It keeps the same 3-bit opcode map but generalises the operand width, registers its outputs and reports carry, zero and overflow flags. It replaces the decrement opcode with an unsigned multiply, computed by a multi-cycle shift-add engine. It sits between an operand-issuing controller and a result consumer, and uses valid/ready on both sides.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  WIDTH  operand A (unsigned; signed view for overflow)
- b  input  WIDTH  operand B
- sel  input  3  opcode: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 SHL, 101 SHR, 110 INC, 111 MUL
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result (MUL: low half of product)
- result_hi  output  WIDTH  MUL: high half of product; 0 for all other ops
- carry  output  1  carry/borrow/shift-out flag
- zero  output  1  result (MUL: full 2*WIDTH product) equals 0
- overflow  output  1  signed overflow

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL in progress.
  - DONE: out_valid=1.
- IDLE, in_valid=1, sel!=111: compute and register result/flags, go to DONE.
- IDLE, in_valid=1, sel=111: latch a/b, clear the accumulator and step counter, go to BUSY.
- BUSY: one shift-add step per cycle (if multiplier LSB, add multiplicand to acc; shift). After WIDTH steps, register the product and flags, go to DONE.
- DONE: hold all outputs stable. Go to IDLE on out_ready=1. Inputs are ignored outside IDLE.
- Width rules: all ops modulo 2^WIDTH. SHL/SHR shift by 1 with zero fill. INC is a+1. b is ignored for SHL/SHR/INC.
- carry:
  - ADD/INC: carry-out.
  - SUB: borrow (1 iff a<b unsigned).
  - SHL: a[WIDTH-1]; SHR: a[0].
  - OR/AND: 0.
  - MUL: 1 iff result_hi != 0.
- overflow:
  - ADD/INC: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
  - Other ops: 0.

## Timing
- Reset (async assert, sync release by design): state=IDLE, in_ready=1, out_valid=0, result=result_hi=0, carry=zero=overflow=0, counter=0.
- Reset while BUSY or DONE aborts the operation. Nothing is emitted after release.
- Single-cycle op accepted on edge k: out_valid=1 from edge k+1.
- MUL accepted on edge k: steps on edges k+1..k+WIDTH, out_valid=1 from edge k+WIDTH (latency WIDTH).
- Transfer at an edge with out_valid & out_ready. out_valid drops on that edge and in_ready rises on that edge. The next operation can be accepted one edge later, so peak throughput is one op per 2 cycles.
- out_ready may be high before out_valid; this is allowed and has no effect.
- out_ready held low keeps DONE indefinitely with outputs unchanged.
- in_ready is a combinational decode of state only. It has no dependence on in_valid or out_ready.

## Test plan
- Reset then ADD a=0xFF b=0x01 (WIDTH=8) -> after 1 cycle: result=0x00, carry=1, zero=1, overflow=0, result_hi=0.
- SUB a=0x80 b=0x01 -> result=0x7F, carry=0, overflow=1. Then SUB a=0x01 b=0x02 -> result=0xFF, carry=1, overflow=0.
- MUL a=0xFF b=0xFF -> out_valid exactly 8 cycles after acceptance: result_hi=0xFE, result=0x01, carry=1, zero=0. Also MUL a=0x00 b=0x5A -> zero=1, carry=0.
- SHL a=0x81 -> result=0x02, carry=1. SHR a=0x81 -> result=0x40, carry=1. INC a=0x7F -> result=0x80, overflow=1.
- Backpressure: out_ready low for 5 cycles after DONE -> outputs constant, in_ready=0, new in_valid ignored. Then out_ready=1 -> out_valid falls and in_ready rises on the same edge.
- Assert rst_n low 3 cycles into a MUL -> all outputs 0 immediately, in_ready=1. After release, no out_valid until a new op is issued.
